// File: rtl/board_gen_stream.sv
// Streams an N x N colour board in raster order, one cell per accepted write, colours from a 16-bit LFSR.
// WR_EN rises the cycle after START; a low WR_READY freezes coordinates, colour and LFSR until accepted.
module board_gen_stream #(
   parameter int MAX_SIZE = 26,
   parameter int COLOR_W  = 3,
   parameter int POS_W    = 5
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [15:0]        i_seed,
   input  logic [POS_W-1:0]   i_size,
   input  logic [3:0]         i_color_num,
   input  logic               i_mode,
   input  logic               i_wr_ready,
   output logic               o_wr_en,
   output logic [POS_W-1:0]   o_wr_row,
   output logic [POS_W-1:0]   o_wr_col,
   output logic [COLOR_W-1:0] o_wr_color,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   localparam logic [15:0]      LP_SEED_DEF = 16'hDAD7;
   localparam logic [POS_W-1:0] LP_MAX_SIZE = POS_W'(MAX_SIZE);
   localparam logic [4:0]       LP_K_MAX    = 5'(2**COLOR_W);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [15:0]        r_lfsr;
   logic [POS_W-1:0]   r_size;
   logic [POS_W-1:0]   r_row;
   logic [POS_W-1:0]   r_col;
   logic [3:0]         r_k;
   logic               r_mode;
   logic               r_err;
   logic [COLOR_W-1:0] r_left;
   logic [COLOR_W-1:0] r_rowbuf [MAX_SIZE];

   logic               w_legal;
   logic               w_accept;
   logic               w_last_col;
   logic               w_last_row;
   logic [3:0]         w_base;
   logic [3:0]         w_cand1;
   logic [3:0]         w_cand2;
   logic [3:0]         w_up;
   logic               w_bad0;
   logic               w_bad1;
   logic [3:0]         w_color;

   assign w_legal = (i_size >= POS_W'(2)) && (i_size <= LP_MAX_SIZE) &&
                    (i_color_num >= 4'd3) && ({1'b0, i_color_num} <= LP_K_MAX);
   assign w_accept   = (r_state == S_RUN) && i_wr_ready;
   assign w_last_col = (r_col == r_size - POS_W'(1));
   assign w_last_row = (r_row == r_size - POS_W'(1));

   // Candidates b, b+1, b+2 (mod K) are distinct because K >= 3, so one always survives two exclusions.
   assign w_base  = 4'(r_lfsr % {12'd0, r_k});
   assign w_cand1 = (w_base + 4'd1 == r_k) ? 4'd0 : w_base + 4'd1;
   assign w_cand2 = (w_cand1 + 4'd1 == r_k) ? 4'd0 : w_cand1 + 4'd1;
   assign w_up    = 4'(r_rowbuf[r_col]);
   assign w_bad0  = ((r_col != '0) && (w_base == 4'(r_left))) ||
                    ((r_row != '0) && (w_base == w_up));
   assign w_bad1  = ((r_col != '0) && (w_cand1 == 4'(r_left))) ||
                    ((r_row != '0) && (w_cand1 == w_up));

   always_comb begin
      w_color = w_base;
      if (r_mode && w_bad0) begin
         w_color = w_bad1 ? w_cand2 : w_cand1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start && w_legal) w_state_nxt = S_RUN;
         S_RUN:   if (w_accept && w_last_col && w_last_row) w_state_nxt = S_FIN;
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lfsr <= LP_SEED_DEF;
         r_size <= '0;
         r_k    <= '0;
         r_mode <= 1'b0;
         r_row  <= '0;
         r_col  <= '0;
         r_left <= '0;
         r_err  <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (r_state == S_IDLE && i_start) begin
            if (w_legal) begin
               r_size <= i_size;
               r_k    <= i_color_num;
               r_mode <= i_mode;
               r_lfsr <= (i_seed == 16'd0) ? LP_SEED_DEF : i_seed;
               r_row  <= '0;
               r_col  <= '0;
            end else begin
               r_err <= 1'b1;
            end
         end else if (w_accept) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_left <= COLOR_W'(w_color);
            if (w_last_col) begin
               r_col <= '0;
               r_row <= w_last_row ? '0 : r_row + POS_W'(1);
            end else begin
               r_col <= r_col + POS_W'(1);
            end
         end
      end
   end

   // Row buffer is always written before it is read within a board, so it carries no reset.
   always_ff @(posedge i_clk) begin
      if (w_accept) r_rowbuf[r_col] <= COLOR_W'(w_color);
   end

   assign o_wr_en    = (r_state == S_RUN);
   assign o_wr_row   = r_row;
   assign o_wr_col   = r_col;
   assign o_wr_color = (r_state == S_RUN) ? COLOR_W'(w_color) : '0;
   assign o_busy     = (r_state != S_IDLE);
   assign o_done     = (r_state == S_FIN);
   assign o_err      = r_err;

endmodule

// File: tb/tb_board_gen_stream.sv
// Randomized bench for board_gen_stream against a cell-by-cell reference board model.
module tb_board_gen_stream;

   logic       i_clk = 1'b0;
   logic       i_rst, i_start, i_mode, i_wr_ready;
   logic [15:0] i_seed;
   logic [4:0] i_size;
   logic [3:0] i_color_num;
   logic       o_wr_en, o_busy, o_done, o_err;
   logic [4:0] o_wr_row, o_wr_col;
   logic [2:0] o_wr_color;

   int tests = 0;
   int fails = 0;
   int q_row[$], q_col[$], q_color[$];
   int e_row[$], e_col[$], e_color[$];

   board_gen_stream dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_seed(i_seed),
      .i_size(i_size), .i_color_num(i_color_num), .i_mode(i_mode),
      .i_wr_ready(i_wr_ready), .o_wr_en(o_wr_en), .o_wr_row(o_wr_row),
      .o_wr_col(o_wr_col), .o_wr_color(o_wr_color), .o_busy(o_busy),
      .o_done(o_done), .o_err(o_err));

   always #5 i_clk = ~i_clk;

   function automatic logic [15:0] lfsr_next(input logic [15:0] r);
      return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
   endfunction

   // Reference: walk the board in raster order applying the colour rules directly.
   task automatic model_board(input logic [15:0] seed, input int n, input int k, input bit mode);
      int board[26][26];
      logic [15:0] r;
      int b, c;
      e_row.delete(); e_col.delete(); e_color.delete();
      r = (seed == 16'd0) ? 16'hDAD7 : seed;
      for (int row = 0; row < n; row++) begin
         for (int col = 0; col < n; col++) begin
            b = int'(r % 16'(k));
            c = b;
            if (mode) begin
               for (int t = 2; t >= 0; t--) begin
                  if (!((col > 0 && (b + t) % k == board[row][col-1]) ||
                        (row > 0 && (b + t) % k == board[row-1][col])))
                     c = (b + t) % k;
               end
            end
            board[row][col] = c;
            e_row.push_back(row); e_col.push_back(col); e_color.push_back(c);
            r = lfsr_next(r);
         end
      end
   endtask

   function automatic int seq_mismatch();
      int m = 0;
      if (q_row.size() != e_row.size()) return 1 + e_row.size();
      for (int i = 0; i < q_row.size(); i++)
         if (q_row[i] != e_row[i] || q_col[i] != e_col[i] || q_color[i] != e_color[i]) m++;
      return m;
   endfunction

   task automatic run_board(input logic [15:0] seed, input int n, input int k, input bit mode,
                            input int stall_pct, input bit hold_start,
                            output int nwr, output int ndone, output int t_done, output bit timeout);
      int budget;
      q_row.delete(); q_col.delete(); q_color.delete();
      nwr = 0; ndone = 0; t_done = -1; timeout = 1'b1;
      budget = n * n * 4 + 50;
      @(negedge i_clk);
      i_seed = seed; i_size = 5'(n); i_color_num = 4'(k); i_mode = mode;
      i_start = 1'b1; i_wr_ready = 1'b1;
      @(negedge i_clk);
      if (!hold_start) i_start = 1'b0;
      i_seed = 16'($urandom); i_size = 5'($urandom); i_color_num = 4'($urandom); i_mode = 1'($urandom);
      for (int cyc = 1; cyc <= budget; cyc++) begin
         if (cyc > 1) @(negedge i_clk);
         i_wr_ready = ($urandom_range(99) >= stall_pct);
         if (o_wr_en && i_wr_ready) begin
            q_row.push_back(int'(o_wr_row)); q_col.push_back(int'(o_wr_col));
            q_color.push_back(int'(o_wr_color));
            nwr++;
         end
         if (o_done) begin
            ndone++;
            if (t_done < 0) t_done = cyc;
            i_start = 1'b0;
         end
         if (t_done >= 0 && cyc >= t_done + 5) begin
            timeout = 1'b0;
            break;
         end
      end
      i_start = 1'b0; i_wr_ready = 1'b1;
   endtask

   task automatic test_reset();
      tests++; if (o_wr_en !== 1'b0)    begin fails++; $display("FAIL reset_wr_en got %b want 0", o_wr_en); end
      tests++; if (o_busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %b want 0", o_busy); end
      tests++; if (o_done !== 1'b0)     begin fails++; $display("FAIL reset_done got %b want 0", o_done); end
      tests++; if (o_err !== 1'b0)      begin fails++; $display("FAIL reset_err got %b want 0", o_err); end
      tests++; if (o_wr_row !== 5'd0)   begin fails++; $display("FAIL reset_row got %0d want 0", o_wr_row); end
      tests++; if (o_wr_col !== 5'd0)   begin fails++; $display("FAIL reset_col got %0d want 0", o_wr_col); end
      tests++; if (o_wr_color !== 3'd0) begin fails++; $display("FAIL reset_color got %0d want 0", o_wr_color); end
   endtask

   task automatic test_basic();
      int nwr, ndone, t_done, m; bit to;
      run_board(16'd0, 3, 4, 1'b0, 0, 1'b0, nwr, ndone, t_done, to);
      model_board(16'd0, 3, 4, 1'b0);
      tests++; if (to) begin fails++; $display("FAIL basic_timeout got timeout want done"); end
      tests++; if (q_color.size() < 2 || q_color[0] != 3) begin fails++; $display("FAIL basic_cell00 got %0d want 3", q_color.size() ? q_color[0] : -1); end
      tests++; if (q_color.size() < 2 || q_color[1] != 2) begin fails++; $display("FAIL basic_cell01 got %0d want 2", q_color.size() > 1 ? q_color[1] : -1); end
      tests++; if (nwr != 9) begin fails++; $display("FAIL basic_writes got %0d want 9", nwr); end
      tests++; if (t_done != 10) begin fails++; $display("FAIL basic_done_cycle got %0d want 10", t_done); end
      tests++; if (ndone != 1) begin fails++; $display("FAIL basic_done_count got %0d want 1", ndone); end
      m = seq_mismatch();
      tests++; if (m != 0) begin fails++; $display("FAIL basic_sequence got %0d mismatches want 0", m); end
   endtask

   task automatic test_illegal();
      int sizes[4] = '{1, 27, 4, 4};
      int ks[4]    = '{4, 4, 2, 9};
      bit seen;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         i_seed = 16'($urandom); i_size = 5'(sizes[i]); i_color_num = 4'(ks[i]);
         i_start = 1'b1;
         @(negedge i_clk);
         i_start = 1'b0;
         tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL illegal%0d_err got %b want 1", i, o_err); end
         seen = 1'b0;
         for (int c = 0; c < 4; c++) begin
            if (c > 0 && o_err) seen = 1'b1;
            if (o_wr_en || o_busy) seen = 1'b1;
            @(negedge i_clk);
         end
         tests++; if (seen) begin fails++; $display("FAIL illegal%0d_quiet got activity want none", i); end
      end
   endtask

   task automatic test_random();
      int nwr, ndone, t_done, m, n, k; bit to, mode; logic [15:0] seed;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(2, 8); k = $urandom_range(3, 8); mode = 1'($urandom);
         seed = 16'($urandom);
         run_board(seed, n, k, mode, 30, 1'b0, nwr, ndone, t_done, to);
         model_board(seed, n, k, mode);
         m = seq_mismatch();
         tests++; if (to || m != 0 || ndone != 1) begin
            fails++; $display("FAIL random%0d got mism=%0d done=%0d to=%b want 0/1/0", it, m, ndone, to);
         end
      end
   endtask

   task automatic test_mode1();
      int nwr, ndone, t_done, m, bad; bit to; logic [15:0] seed;
      int g[26][26];
      for (int it = 0; it < 2; it++) begin
         seed = 16'($urandom_range(1, 65535));
         run_board(seed, 26, 3, 1'b1, 10, 1'b0, nwr, ndone, t_done, to);
         model_board(seed, 26, 3, 1'b1);
         bad = 0;
         for (int i = 0; i < q_row.size(); i++) g[q_row[i] % 26][q_col[i] % 26] = q_color[i];
         for (int r = 0; r < 26; r++)
            for (int c = 0; c < 26; c++) begin
               if (g[r][c] >= 3) bad++;
               if (c > 0 && g[r][c] == g[r][c-1]) bad++;
               if (r > 0 && g[r][c] == g[r-1][c]) bad++;
            end
         tests++; if (nwr != 676) begin fails++; $display("FAIL mode1_writes got %0d want 676", nwr); end
         tests++; if (bad != 0) begin fails++; $display("FAIL mode1_rule got %0d violations want 0", bad); end
         m = seq_mismatch();
         tests++; if (m != 0 || to) begin fails++; $display("FAIL mode1_sequence got %0d mismatches want 0", m); end
      end
   endtask

   task automatic test_stall();
      int stalls = 0, frozen_bad = 0, m; bit done_seen = 0;
      logic [4:0] h_row, h_col; logic [2:0] h_color;
      logic [15:0] seed;
      seed = 16'($urandom_range(1, 65535));
      q_row.delete(); q_col.delete(); q_color.delete();
      @(negedge i_clk);
      i_seed = seed; i_size = 5'd4; i_color_num = 4'd5; i_mode = 1'b1; i_start = 1'b1; i_wr_ready = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      for (int cyc = 0; cyc < 60 && !done_seen; cyc++) begin
         if (cyc > 0) @(negedge i_clk);
         i_wr_ready = 1'b1;
         if (o_wr_en && o_wr_row == 5'd1 && o_wr_col == 5'd2 && stalls < 3) begin
            if (stalls == 0) begin h_row = o_wr_row; h_col = o_wr_col; h_color = o_wr_color; end
            else if (o_wr_row !== h_row || o_wr_col !== h_col || o_wr_color !== h_color) frozen_bad++;
            i_wr_ready = 1'b0;
            stalls++;
         end
         if (o_wr_en && i_wr_ready) begin
            q_row.push_back(int'(o_wr_row)); q_col.push_back(int'(o_wr_col));
            q_color.push_back(int'(o_wr_color));
         end
         if (o_done) done_seen = 1'b1;
      end
      model_board(seed, 4, 5, 1'b1);
      tests++; if (stalls != 3 || frozen_bad != 0) begin fails++; $display("FAIL stall_frozen got stalls=%0d drift=%0d want 3/0", stalls, frozen_bad); end
      m = seq_mismatch();
      tests++; if (m != 0 || !done_seen) begin fails++; $display("FAIL stall_sequence got %0d mismatches done=%b want 0/1", m, done_seen); end
   endtask

   task automatic test_reset_mid();
      int nwr, ndone, t_done, m, pre_bad = 0; bit to; logic [15:0] seed;
      int first[$];
      seed = 16'($urandom_range(1, 65535));
      @(negedge i_clk);
      i_seed = seed; i_size = 5'd5; i_color_num = 4'd6; i_mode = 1'b1; i_start = 1'b1; i_wr_ready = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      for (int cyc = 0; cyc < 20 && first.size() < 5; cyc++) begin
         if (cyc > 0) @(negedge i_clk);
         if (o_wr_en) first.push_back(int'(o_wr_color));
      end
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      tests++; if (o_wr_en !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL rstmid_idle got wr_en=%b busy=%b want 0/0", o_wr_en, o_busy); end
      run_board(seed, 5, 6, 1'b1, 0, 1'b0, nwr, ndone, t_done, to);
      model_board(seed, 5, 6, 1'b1);
      for (int i = 0; i < 5; i++) if (i >= first.size() || first[i] != e_color[i]) pre_bad++;
      tests++; if (pre_bad != 0) begin fails++; $display("FAIL rstmid_prefix got %0d mismatches want 0", pre_bad); end
      m = seq_mismatch();
      tests++; if (m != 0 || to) begin fails++; $display("FAIL rstmid_rerun got %0d mismatches want 0", m); end
   endtask

   task automatic test_hold_start();
      int nwr, ndone, t_done; bit to;
      run_board(16'h1234, 3, 3, 1'b0, 0, 1'b1, nwr, ndone, t_done, to);
      tests++; if (nwr != 9 || ndone != 1 || to) begin
         fails++; $display("FAIL hold_start got writes=%0d dones=%0d want 9/1", nwr, ndone);
      end
   endtask

   initial begin
      i_rst = 1'b1; i_start = 1'b0; i_seed = '0; i_size = '0; i_color_num = '0;
      i_mode = 1'b0; i_wr_ready = 1'b1;
      repeat (3) @(negedge i_clk);
      test_reset();
      i_rst = 1'b0;
      test_basic();
      test_illegal();
      test_random();
      test_mode1();
      test_stall();
      test_reset_mid();
      test_hold_start();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/board_gen_stream.md
BOARD_GEN_STREAM -- requirements
Module: board_gen_stream

Interface
REQ-001 Parameter MAX_SIZE, default 26: largest supported board edge; sets row-buffer depth.
REQ-002 Parameter COLOR_W, default 3: colour index width; legal COLOR_NUM is 3..2^COLOR_W.
REQ-003 Parameter POS_W, default 5: row/column/size field width; SHALL satisfy 2^POS_W > MAX_SIZE.
REQ-004 CLOCK  in  1  sole clock; all state updates on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 START  in  1  request a new board; sampled only in IDLE.
REQ-007 SEED  in  16  LFSR seed; value 0 selects default 16'hDAD7.
REQ-008 SIZE  in  POS_W  board edge N; board is N x N.
REQ-009 COLOR_NUM  in  4  number of colours K.
REQ-010 MODE  in  1  0 = free random; 1 = no cell equals its left or upper neighbour.
REQ-011 WR_READY  in  1  downstream board memory accepts the write this cycle.
REQ-012 WR_EN  out  1  cell write valid.
REQ-013 WR_ROW, WR_COL  out  POS_W each  cell coordinates.
REQ-014 WR_COLOR  out  COLOR_W  cell colour.
REQ-015 BUSY  out  1  generation in progress.
REQ-016 DONE  out  1  one-cycle pulse, board complete.
REQ-017 ERR  out  1  one-cycle pulse, START rejected for illegal parameters.

Function
REQ-018 States: IDLE, RUN, FIN; FIN lasts exactly one cycle, then IDLE.
REQ-019 IDLE with START=1 and legal parameters (2 <= SIZE <= MAX_SIZE, 3 <= COLOR_NUM <= 2^COLOR_W): latch SIZE, COLOR_NUM, MODE; load LFSR from SEED (or 16'hDAD7 if SEED=0); go RUN.
REQ-020 IDLE with START=1 and illegal parameters: ERR=1 next cycle for one cycle; stay IDLE; LFSR unchanged.
REQ-021 Latched parameters are held through the board; input changes during RUN have no effect.
REQ-022 LFSR step: R_next = {R[14:0], R[15]^R[13]^R[12]^R[10]}; advances only on an accepted write (WR_EN & WR_READY).
REQ-023 Cells are emitted in raster order, (0,0),(0,1)...(0,N-1),(1,0)...(N-1,N-1), one per accepted write.
REQ-024 Base colour b = R mod K using the current (pre-step) LFSR value, full 16-bit remainder.
REQ-025 MODE=0: WR_COLOR = b.
REQ-026 MODE=1: WR_COLOR = first of b, (b+1) mod K, (b+2) mod K differing from the left neighbour (if col>0) and the upper neighbour (if row>0); at (0,0), equals b.
REQ-027 Upper neighbour is read from an internal MAX_SIZE x COLOR_W row buffer, written at index col on each accepted write; left neighbour is held in a register.
REQ-028 WR_EN asserts in the cycle after START is accepted; WR_EN stays high throughout RUN.
REQ-029 While WR_EN=1 and WR_READY=0: WR_ROW, WR_COL and WR_COLOR SHALL hold stable; no LFSR step.
REQ-030 Accepted write at col=N-1 wraps to col 0, row+1; accepted write at (N-1,N-1) goes to FIN with WR_EN=0 next cycle.
REQ-031 DONE=1 only in FIN, i.e. the cycle after the last accepted write; throughput one cell per cycle with WR_READY tied high (N*N+1 cycles START-accept to DONE).
REQ-032 BUSY=1 in RUN and FIN, 0 in IDLE.
REQ-033 START during RUN or FIN is ignored and is not queued.

Reset
REQ-034 RESET=1 at a clock edge forces IDLE, WR_EN=0, WR_ROW=0, WR_COL=0, WR_COLOR=0, BUSY=0, DONE=0, ERR=0, LFSR=16'hDAD7; this takes priority over START and applies mid-board with no further writes.
REQ-035 Row-buffer contents need not be reset; they are never read before being written in the current board.

Verification
REQ-036 SEED=0, SIZE=3, K=4, MODE=0, WR_READY=1 -> (0,0)=3 (0xDAD7 mod 4), (0,1)=2 (0xB5AE mod 4); 9 writes on consecutive cycles; DONE on cycle 10 after accept.
REQ-037 SIZE=1, 27 or COLOR_NUM=2, 9 (COLOR_W=3) -> single ERR pulse; no WR_EN; BUSY stays 0.
REQ-038 MODE=1, SIZE=26, K=3, random seeds -> no cell equals its left or upper neighbour; all colours < 3; 676 writes.
REQ-039 WR_READY low for 3 cycles on cell (1,2) -> outputs frozen; resumed sequence identical to a no-stall run with same seed.
REQ-040 RESET asserted after 5 writes -> WR_EN=0 and BUSY=0 next cycle; new START with same seed reproduces the identical sequence from (0,0).
REQ-041 START held high through RUN -> exactly one board generated; one DONE.
